// File: rtl/alu_mc_pkg.sv
// Shared opcode/state types and constants for alu_mc and its iterative datapath.
// The divider is present only when ALU_MC_DIV_EN is defined.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_NOT   = 4'd4,
        OP_PASSB = 4'd5,
        OP_SLT   = 4'd6,
        OP_MUL   = 4'd7,
        OP_DIVU  = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_HOLD = 2'd3
    } alu_state_t;

    // Result presented for an opcode the block does not implement.
    localparam logic ILLEGAL_FILL = 1'b0;
    localparam logic ILLEGAL_ERR  = 1'b1;
    localparam logic ILLEGAL_ZERO = 1'b1;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared one-bit-per-cycle engine for unsigned MUL (shift-add) and DIVU (restoring).
// The divide datapath is compiled in only when ALU_MC_DIV_EN is defined.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             dz_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q;
    logic             mode_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH:0]   addend_s;
    logic [WIDTH:0]   sum_s;
`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
`endif

    // One iteration: MUL shifts {acc,sh} right after a conditional add, DIV shifts left and trial-subtracts.
    always_comb begin
        acc_d    = acc_q;
        sh_d     = sh_q;
        addend_s = '0;
        sum_s    = '0;
`ifdef ALU_MC_DIV_EN
        shifted_s = '0;
        trial_s   = '0;
`endif
        if (mode_q == 1'b0) begin
            if (sh_q[0]) begin
                addend_s = {1'b0, opb_q};
            end else begin
                addend_s = '0;
            end
            sum_s = {1'b0, acc_q} + addend_s;
            acc_d = sum_s[WIDTH:1];
            sh_d  = {sum_s[0], sh_q[WIDTH-1:1]};
        end else begin
`ifdef ALU_MC_DIV_EN
            // A zero divisor always "fits", giving all-ones quotient and remainder equal to the dividend.
            shifted_s = {acc_q, sh_q[WIDTH-1]};
            trial_s   = shifted_s - {1'b0, opb_q};
            if (shifted_s >= {1'b0, opb_q}) begin
                acc_d = trial_s[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted_s[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
`else
            acc_d = acc_q;
            sh_d  = sh_q;
`endif
        end
    end

    // Operand capture on start, then WIDTH iterations counted 0..WIDTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            opb_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            mode_q <= div_i;
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= a_i;
            opb_q  <= b_i;
        end else if (busy_q) begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign done_o = busy_q && (cnt_q == LAST);
    assign lo_o   = sh_d;
    assign hi_o   = acc_d;
`ifdef ALU_MC_DIV_EN
    assign dz_o   = mode_q && (opb_q == '0);
`else
    assign dz_o   = 1'b0;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready handshake and registered results.
// Defining ALU_MC_DIV_EN adds unsigned divide (opcode 8); otherwise opcode 8 is illegal.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             err
);

    alu_state_t       state_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_hi_q;
    logic             zero_q;
    logic             err_q;

    alu_op_t          op_s;
    logic [WIDTH-1:0] res_d;
    logic             err_d;
    logic             go_mul_s;
    logic             go_div_s;
    logic             accept_s;
    logic             start_s;
    logic             iter_done_s;
    logic [WIDTH-1:0] iter_lo_s;
    logic [WIDTH-1:0] iter_hi_s;
    logic             iter_dz_s;

    assign op_s     = alu_op_t'(op);
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept_s = in_valid && in_ready;
    assign start_s  = accept_s && (go_mul_s || go_div_s);

    // Single-cycle result and long-op decode; only ever feeds registers.
    always_comb begin
        res_d    = '0;
        err_d    = 1'b0;
        go_mul_s = 1'b0;
        go_div_s = 1'b0;
        case (op_s)
            OP_ADD:   res_d = ina + inb;
            OP_SUB:   res_d = inb - ina;
            OP_AND:   res_d = ina & inb;
            OP_OR:    res_d = ina | inb;
            OP_NOT:   res_d = ~ina;
            OP_PASSB: res_d = inb;
            OP_SLT:   res_d = {{(WIDTH-1){1'b0}}, ($signed(ina) < $signed(inb))};
            OP_MUL:   go_mul_s = 1'b1;
`ifdef ALU_MC_DIV_EN
            OP_DIVU:  go_div_s = 1'b1;
`endif
            default: begin
                res_d = {WIDTH{ILLEGAL_FILL}};
                err_d = ILLEGAL_ERR;
            end
        endcase
    end

    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_s),
        .div_i   (go_div_s),
        .a_i     (ina),
        .b_i     (inb),
        .done_o  (iter_done_s),
        .lo_o    (iter_lo_s),
        .hi_o    (iter_hi_s),
        .dz_o    (iter_dz_s)
    );

    // Control FSM and result registers; a reset mid-iteration drops the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            out_hi_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s) begin
                        if (go_div_s) begin
                            state_q <= ST_DIV;
                        end else if (go_mul_s) begin
                            state_q <= ST_MUL;
                        end else begin
                            state_q  <= ST_HOLD;
                            out_q    <= res_d;
                            out_hi_q <= '0;
                            zero_q   <= err_d ? ILLEGAL_ZERO : (res_d == '0);
                            err_q    <= err_d;
                        end
                    end else if ((state_q == ST_HOLD) && out_ready) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= state_q;
                    end
                end
`ifdef ALU_MC_DIV_EN
                ST_MUL, ST_DIV: begin
`else
                ST_MUL: begin
`endif
                    if (iter_done_s) begin
                        state_q  <= ST_HOLD;
                        out_q    <= iter_lo_s;
                        out_hi_q <= iter_hi_s;
                        zero_q   <= (iter_lo_s == '0);
                        err_q    <= iter_dz_s;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: scoreboard of expected results from a plain
// arithmetic model, per-cycle compare process, plus directed literal checks.
module tb_alu_mc;

    localparam int W  = 16;
    localparam int W2 = 32;
`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] o;
        logic [W-1:0] h;
        logic         z;
        logic         e;
        int           lat;
        int           due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  ina = '0;
    logic [W-1:0]  inb = '0;
    logic [3:0]    op = 4'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  dout;
    logic [W-1:0]  dout_hi;
    logic          zero;
    logic          err;

    logic          v32 = 1'b0;
    logic          rdy32;
    logic [W2-1:0] a32 = '0;
    logic [W2-1:0] b32 = '0;
    logic [3:0]    op32 = 4'd0;
    logic          ov32;
    logic          ordy32 = 1'b1;
    logic [W2-1:0] o32;
    logic [W2-1:0] h32;
    logic          z32;
    logic          e32;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    bit   head_seen = 1'b0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ina(ina), .inb(inb), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(dout), .out_hi(dout_hi), .zero(zero), .err(err)
    );

    alu_mc #(.WIDTH(W2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
        .ina(a32), .inb(b32), .op(op32), .out_valid(ov32), .out_ready(ordy32),
        .out(o32), .out_hi(h32), .zero(z32), .err(e32)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] aa;
        logic [2*W-1:0] bb;
        logic [2*W-1:0] p;
        aa = {{W{1'b0}}, a};
        bb = {{W{1'b0}}, b};
        e.o = '0; e.h = '0; e.e = 1'b0; e.lat = 1; e.due = 0;
        case (o)
            4'd0: e.o = a + b;
            4'd1: e.o = b - a;
            4'd2: e.o = a & b;
            4'd3: e.o = a | b;
            4'd4: e.o = ~a;
            4'd5: e.o = b;
            4'd6: e.o = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd7: begin
                p = aa * bb;
                e.o = p[W-1:0];
                e.h = p[2*W-1:W];
                e.lat = W + 1;
            end
            4'd8: begin
                if (DIV_EN) begin
                    e.lat = W + 1;
                    if (b == '0) begin
                        e.o = '1; e.h = a; e.e = 1'b1;
                    end else begin
                        e.o = a / b; e.h = a % b;
                    end
                end else begin
                    e.e = 1'b1;
                end
            end
            default: e.e = 1'b1;
        endcase
        e.z = (e.o == '0);
        return e;
    endfunction

    // Compare process: every cycle with a result, check value and first-valid latency.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb.delete();
            head_seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_valid actual=out_valid=1 required=no result pending");
            end else begin
                if (!head_seen) begin
                    chk("latency", 64'(cyc), 64'(sb[0].due));
                    head_seen = 1'b1;
                end
                chk("out", 64'(dout), 64'(sb[0].o));
                chk("out_hi", 64'(dout_hi), 64'(sb[0].h));
                chk("zero", 64'(zero), 64'(sb[0].z));
                chk("err", 64'(err), 64'(sb[0].e));
                if (out_ready) begin
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one operation; returns #1 after the accept edge with inputs scrambled.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int wt);
        exp_t e;
        e = model(o, a, b);
        op = o; ina = a; inb = b; in_valid = 1'b1;
        wt = 0;
        @(negedge clk);
        while (!in_ready && wt < 100) begin
            @(negedge clk);
            wt = wt + 1;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'(1));
        end else begin
            e.due = cyc + e.lat;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        ina = W'($urandom);
        inb = W'($urandom);
        op = 4'($urandom);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n = n + 1;
        end
        chk("drain", 64'(sb.size()), 64'(0));
    endtask

    logic [3:0]   t_op [15] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6,
                                4'd7, 4'd0, 4'd8, 4'd9, 4'd7, 4'd0};
    logic [W-1:0] t_a  [15] = '{16'h0005, 16'hF0F0, 16'hF0F0, 16'h0000, 16'hFFFF, 16'h1234, 16'h8000,
                                16'h7FFF, 16'h0005, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h1111, 16'h0000, 16'h0009};
    logic [W-1:0] t_b  [15] = '{16'h0003, 16'h3C3C, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF,
                                16'h8000, 16'h0005, 16'h5678, 16'h0001, 16'h0001, 16'h2222, 16'hABCD, 16'h0001};

    initial begin
        int wt;
        int bad;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out", 64'(dout), 64'(0));
        chk("rst_out_hi", 64'(dout_hi), 64'(0));
        chk("rst_zero", 64'(zero), 64'(1));
        chk("rst_err", 64'(err), 64'(0));

        issue(4'd0, 16'd3, 16'd5, wt);
        chk("add_lit", 64'(dout), 64'(8));
        chk("b2b_wait_add", 64'(wt), 64'(0));
        issue(4'd1, 16'd2, 16'd7, wt);
        chk("sub_lit", 64'(dout), 64'(5));
        chk("b2b_wait_sub", 64'(wt), 64'(0));
        issue(4'd6, 16'hFFFF, 16'd1, wt);
        chk("slt_lit", 64'(dout), 64'(1));
        chk("b2b_wait_slt", 64'(wt), 64'(0));

        issue(4'd7, 16'hFFFF, 16'hFFFF, wt);
        bad = 0;
        for (int k = 1; k <= W; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = bad + 1;
            tick();
        end
        chk("mul_busy_cycles", 64'(bad), 64'(0));
        chk("mul_valid_17", 64'(out_valid), 64'(1));
        chk("mul_lo_lit", 64'(dout), 64'(16'h0001));
        chk("mul_hi_lit", 64'(dout_hi), 64'(16'hFFFE));

        issue(4'd8, 16'd100, 16'd7, wt);
`ifdef ALU_MC_DIV_EN
        repeat (W) tick();
        chk("divu_q_lit", 64'(dout), 64'(14));
        chk("divu_r_lit", 64'(dout_hi), 64'(2));
        chk("divu_err_lit", 64'(err), 64'(0));
`else
        chk("op8_out_lit", 64'(dout), 64'(0));
        chk("op8_err_lit", 64'(err), 64'(1));
`endif
        issue(4'd8, 16'd9, 16'd0, wt);
`ifdef ALU_MC_DIV_EN
        repeat (W) tick();
        chk("div0_q_lit", 64'(dout), 64'(16'hFFFF));
        chk("div0_r_lit", 64'(dout_hi), 64'(9));
        chk("div0_err_lit", 64'(err), 64'(1));
`else
        chk("op8b_err_lit", 64'(err), 64'(1));
`endif
        issue(4'd12, 16'h1234, 16'h4321, wt);
        chk("op12_out_lit", 64'(dout), 64'(0));
        chk("op12_err_lit", 64'(err), 64'(1));
        drain();

        out_ready = 1'b0;
        issue(4'd0, 16'd1, 16'hFFFF, wt);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || dout !== '0 || zero !== 1'b1 || in_ready !== 1'b0) bad = bad + 1;
            tick();
        end
        chk("hold_stable", 64'(bad), 64'(0));
        out_ready = 1'b1;
        #1;
        chk("hold_in_ready_comb", 64'(in_ready), 64'(1));
        tick();
        chk("hold_consumed", 64'(out_valid), 64'(0));

        issue(4'd7, 16'h1234, 16'h5678, wt);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_out", 64'(dout), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;
        repeat (W + 2) tick();
        chk("abort_no_result", 64'(out_valid), 64'(0));
        issue(4'd0, 16'd7, 16'd9, wt);
        chk("after_abort_add", 64'(dout), 64'(16));

        for (int i = 0; i < 15; i++) issue(t_op[i], t_a[i], t_b[i], wt);
        for (int i = 0; i < 20; i++) issue(4'($urandom_range(15, 0)), W'($urandom), W'($urandom), wt);
        drain();

        a32 = 32'hFFFF_FFFF; b32 = 32'd3; op32 = 4'd7; v32 = 1'b1;
        @(negedge clk);
        chk("w32_in_ready", 64'(rdy32), 64'(1));
        tick();
        v32 = 1'b0;
        a32 = '0; b32 = '0;
        lat = 1;
        while (!ov32 && lat < 100) begin
            tick();
            lat = lat + 1;
        end
        chk("w32_mul_latency", 64'(lat), 64'(W2 + 1));
        chk("w32_mul_product", {h32, o32}, 64'h0000_0002_FFFF_FFFD);
        chk("w32_mul_err", 64'(e32), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the 16-bit single-cycle ALU used in the EX stage. It keeps the existing six operations and adds signed set-less-than, an iterative unsigned multiply and an optional unsigned divide. Every result is registered behind a valid/ready handshake, so the pipeline controller can stall the EX stage while a long operation is in flight.

## Interface
- `WIDTH`, 16: operand and result width, ≥4.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands and opcode present.
- `in_ready`, output, 1: block can accept an operation this cycle.
- `ina`, input, WIDTH: operand A.
- `inb`, input, WIDTH: operand B.
- `op`, input, 4: opcode, encoded as `alu_op_t` in `alu_mc_pkg`.
- `out_valid`, output, 1: result registers hold a result.
- `out_ready`, input, 1: consumer takes the result this cycle.
- `out`, output, WIDTH: primary result.
- `out_hi`, output, WIDTH: MUL high half or DIVU remainder; 0 for other ops.
- `zero`, output, 1: `out == 0`, registered with `out`.
- `err`, output, 1: illegal opcode, or divide by zero.

## Operation
- Opcodes:
  - 0 ADD: `ina+inb`.
  - 1 SUB: `inb-ina` (operand order kept from the existing ALU).
  - 2 AND.
  - 3 OR.
  - 4 NOT: `~ina`.
  - 5 PASSB: `inb`.
  - 6 SLT: signed `ina<inb`, gives 1 or 0.
  - 7 MUL: unsigned; `{out_hi,out}` = full 2·WIDTH product.
  - 8 DIVU: `out` = quotient, `out_hi` = remainder.
  - 9–15: illegal.
- Arithmetic wraps modulo 2^WIDTH; there is no overflow flag.
- Illegal opcode: `out=0`, `out_hi=0`, `zero=1`, `err=1`, single-cycle latency.
- DIVU with `inb==0`: `out` = all ones, `out_hi` = `ina`, `err=1`. Still WIDTH+1 cycles.
- FSM states: IDLE, MUL, DIV, HOLD.
  - IDLE: accept when `in_valid && in_ready`.
    - Single-cycle op: load result, go HOLD.
    - MUL: go MUL. DIVU: go DIV.
  - MUL: shift-add, one bit per cycle, iteration counter runs 0..WIDTH-1. On the last iteration load the result, go HOLD.
  - DIV: restoring divide, one bit per cycle, same counter. Last iteration → HOLD.
  - HOLD: `out_valid=1`.
    - `out_ready=1` with no new accept → IDLE.
    - Accept in the same cycle (single-cycle op) → stay HOLD, result replaced.
    - Accept in the same cycle (MUL or DIVU) → MUL or DIV.
- `in_ready` = (state==IDLE) || (state==HOLD && out_ready). It is never high in MUL or DIV.
- Operands are captured at accept. Later changes to `ina`/`inb`/`op` do not affect an in-flight operation.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset values: state=IDLE, `out_valid=0`, `in_ready=1` (combinational from IDLE), `out=0`, `out_hi=0`, `zero=1`, `err=0`, counter=0. Reset mid-MUL/DIV aborts the operation with no result produced.

## Timing
- Latency is counted from the accept edge to the first cycle with `out_valid` high.
  - Single-cycle ops and illegal opcodes: 1 cycle.
  - MUL, DIVU: WIDTH+1 cycles (WIDTH iterations, then result load).
- Throughput:
  - Single-cycle ops: 1 per cycle while `out_ready=1`.
  - MUL/DIVU: one per WIDTH+1 cycles.
- `zero` and `err` change only together with `out`.
- No combinational path from `ina`/`inb`/`op` to any output. The only combinational path is `out_ready` → `in_ready`.

## Configuration
- Macro: `ALU_MC_DIV_EN`.
- Defined: DIVU implemented as above, including the DIV state and remainder datapath.
- Undefined:
  - Opcode 8 is treated as illegal (`out=0`, `err=1`, latency 1).
  - DIV state and divider logic are absent.
  - All other behaviour is identical.

## Structure
- `alu_mc_pkg` holds:
  - `alu_op_t` (4-bit enum, values above);
  - `alu_state_t` (IDLE/MUL/DIV/HOLD);
  - the illegal-result constants.
- One sub-module, `alu_mc_iter`, holds the shared shift register, accumulator and iteration counter for MUL and DIVU. It takes a mode input and asserts `done` on its last iteration.
- Single-cycle logic, FSM and output registers live in `alu_mc`.

## Test plan
- WIDTH=16, `out_ready=1`, back-to-back ADD 3+5, SUB a=2 b=7, SLT a=0xFFFF b=1 → `out` = 8, 5, 1 on consecutive cycles; `in_ready` stays high.
- MUL 0xFFFF×0xFFFF → after 17 cycles `out`=0x0001, `out_hi`=0xFFFE; `in_ready` low for cycles 1–16.
- DIVU 100/7 → `out`=14, `out_hi`=2, `err`=0. DIVU 9/0 → `out`=0xFFFF, `out_hi`=9, `err`=1.
- Hold `out_ready=0` for 5 cycles after ADD 1+(-1) → `out`=0 and `zero`=1 stay stable; `in_ready`=0; the result is consumed on the first cycle `out_ready`=1.
- Assert `rst` at iteration 8 of MUL → next cycle state IDLE, `out_valid`=0, `out`=0; the following ADD completes normally.
- Build without `ALU_MC_DIV_EN`, issue op 8 and op 12 → both `out`=0, `err`=1, latency 1. Repeat with WIDTH=32 for MUL → latency 33.
